// File: rtl/wav_pkg.sv
// Shared WAV definitions for the stream encoder and the parser.
// Contents: RIFF/WAVE chunk IDs (ASCII, first character in the MSB), fixed
// header constants, the encoder FSM state type and a helper that turns a chunk
// ID into the little-endian word whose byte lanes are sent in order.
package wav_pkg;

  localparam logic [31:0] RIFF_ID = 32'h5249_4646;  // "RIFF"
  localparam logic [31:0] WAVE_ID = 32'h5741_5645;  // "WAVE"
  localparam logic [31:0] FMT_ID  = 32'h666D_7420;  // "fmt "
  localparam logic [31:0] DATA_ID = 32'h6461_7461;  // "data"

  localparam int WAV_HDR_LEN   = 44;
  localparam int FMT_CHUNK_LEN = 16;
  localparam int WAV_FMT_PCM   = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_PAD    = 3'd3,
    ST_DONE   = 3'd4
  } wav_tx_state_t;

  // Chunk IDs are written character-first, so lane 0 of the returned word
  // holds the first character.
  function automatic logic [31:0] id_to_le(input logic [31:0] id);
    return {id[7:0], id[15:8], id[23:16], id[31:24]};
  endfunction

endpackage

// File: rtl/wav_header_byte.sv
// Combinational lookup of one byte of the canonical 44-byte PCM WAV header
// (mono, 8-bit).
// Ports:
//   index       header byte position 0..43 (positions >= 44 return 0)
//   riff_size   RIFF chunk size field
//   data_size   data chunk size field
//   sample_rate fmt sample rate; also used as byte rate (1 byte per frame)
//   hdr_byte    header byte at index
module wav_header_byte
  import wav_pkg::*;
(
  input  logic [5:0]  index,
  input  logic [31:0] riff_size,
  input  logic [31:0] data_size,
  input  logic [31:0] sample_rate,
  output logic [7:0]  hdr_byte
);

  logic [31:0] word;
  logic [31:0] shifted;

  // The header is eleven 32-bit little-endian words; index[5:2] picks the
  // word, index[1:0] the byte lane.
  always_comb begin
    word = '0;
    case (index[5:2])
      4'd0:    word = id_to_le(RIFF_ID);
      4'd1:    word = riff_size;
      4'd2:    word = id_to_le(WAVE_ID);
      4'd3:    word = id_to_le(FMT_ID);
      4'd4:    word = 32'(FMT_CHUNK_LEN);
      4'd5:    word = {16'd1, 16'(WAV_FMT_PCM)};  // channels, audio format
      4'd6:    word = sample_rate;
      4'd7:    word = sample_rate;                // byte rate
      4'd8:    word = {16'd8, 16'd1};             // bits per sample, block align
      4'd9:    word = id_to_le(DATA_ID);
      4'd10:   word = data_size;
      default: word = '0;
    endcase
    shifted  = word >> {index[1:0], 3'b000};
    hdr_byte = shifted[7:0];
  end

endmodule

// File: rtl/wav_stream_tx.sv
// Encodes a stream of signed 8-bit mono samples into a PCM WAV byte stream
// (44-byte header followed by offset-binary data) on a valid/ready byte port.
// Build option: WAV_STREAM_PAD_EN appends one 0x00 pad byte to odd-length
// data and counts it in the RIFF size; undefined, odd files are unpadded.
// Ports:
//   clk_in, rst_in            sys_clk and synchronous active-high reset
//   start_in, num_samples_in  begin a file of num_samples_in samples (IDLE only)
//   sample_in/valid/ready     signed sample input handshake
//   byte_out/valid/ready      WAV byte output handshake
//   busy_out, done_out        file in progress / one-cycle completion pulse
//   state_out                 FSM state for LED debug
//
// state  | meaning
// IDLE   | waiting for start_in
// HEADER | emitting header bytes 0..43 from the lookup
// DATA   | forwarding converted samples through the output register
// PAD    | emitting the 0x00 pad byte (odd length, pad build only)
// DONE   | one-cycle done_out pulse
module wav_stream_tx
  import wav_pkg::*;
#(
  parameter int SAMPLE_RATE   = 12_000,
  parameter int MAX_SAMPLES_W = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic [MAX_SAMPLES_W-1:0] num_samples_in,
  input  logic [7:0]               sample_in,
  input  logic                     sample_valid_in,
  output logic                     sample_ready_out,
  output logic [7:0]               byte_out,
  output logic                     byte_valid_out,
  input  logic                     byte_ready_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [2:0]               state_out
);

`ifdef WAV_STREAM_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  wav_tx_state_t            state_q, state_d;
  logic [5:0]               idx_q, idx_d;
  logic [MAX_SAMPLES_W-1:0] count_q;
  logic [MAX_SAMPLES_W-1:0] remaining_q;
  logic [7:0]               byte_q;
  logic                     byte_valid_q;

  logic [31:0] data_size;
  logic [31:0] riff_size;
  logic        pad_needed;
  logic [7:0]  hdr_byte;
  logic        hdr_last;
  logic        sample_take;
  logic        out_free;

  assign data_size  = 32'(count_q);
  assign pad_needed = PAD_EN & count_q[0];
  assign riff_size  = 32'd36 + data_size + {31'd0, pad_needed};
  assign hdr_last   = (idx_q == 6'(WAV_HDR_LEN - 1));

  // Output register can take a new byte when empty or being emptied now.
  assign out_free    = !byte_valid_q || byte_ready_in;
  assign sample_take = sample_valid_in && sample_ready_out;

  wav_header_byte u_hdr (
    .index       (idx_q),
    .riff_size   (riff_size),
    .data_size   (data_size),
    .sample_rate (32'(SAMPLE_RATE)),
    .hdr_byte    (hdr_byte)
  );

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    sample_ready_out = 1'b0;
    byte_valid_out   = 1'b0;
    byte_out         = 8'h00;
    busy_out         = 1'b0;
    done_out         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_HEADER;
          idx_d   = '0;
        end
      end
      ST_HEADER: begin
        busy_out       = 1'b1;
        byte_valid_out = 1'b1;
        byte_out       = hdr_byte;
        if (byte_ready_in) begin
          if (hdr_last) begin
            state_d = (data_size != 32'd0) ? ST_DATA : ST_DONE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_DATA: begin
        busy_out         = 1'b1;
        byte_valid_out   = byte_valid_q;
        byte_out         = byte_q;
        sample_ready_out = (remaining_q != '0) && out_free;
        // Leave only once every sample is in and the last byte has drained.
        if (remaining_q == '0 && out_free) begin
          state_d = pad_needed ? ST_PAD : ST_DONE;
        end
      end
      ST_PAD: begin
        busy_out       = 1'b1;
        byte_valid_out = 1'b1;
        byte_out       = 8'h00;
        if (byte_ready_in) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_out = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      remaining_q  <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == ST_IDLE && start_in) begin
        count_q     <= num_samples_in;
        remaining_q <= num_samples_in;
      end
      if (sample_take) begin
        byte_q       <= {~sample_in[7], sample_in[6:0]};
        byte_valid_q <= 1'b1;
        remaining_q  <= remaining_q - 1'b1;
      end else if (state_q != ST_DATA || byte_ready_in) begin
        byte_valid_q <= 1'b0;
      end
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_wav_stream_tx.sv
module tb_wav_stream_tx;

`ifdef WAV_STREAM_PAD_EN
  localparam int P_ODD = 1;
`else
  localparam int P_ODD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [31:0] num_samples_in;
  logic [7:0]  sample_in;
  logic        sample_valid_in;
  logic        sample_ready_out;
  logic [7:0]  byte_out;
  logic        byte_valid_out;
  logic        byte_ready_in;
  logic        busy_out;
  logic        done_out;
  logic [2:0]  state_out;

  always #5 clk = ~clk;

  wav_stream_tx #(.SAMPLE_RATE(12_000), .MAX_SAMPLES_W(32)) dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .start_in         (start_in),
    .num_samples_in   (num_samples_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .sample_ready_out (sample_ready_out),
    .byte_out         (byte_out),
    .byte_valid_out   (byte_valid_out),
    .byte_ready_in    (byte_ready_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .state_out        (state_out)
  );

  typedef struct {
    int         n;
    int         pct;        // byte_ready_in high probability in percent
    int         starve_at;  // sample index where valid drops for 10 cycles (-1 none)
    bit         glitch;     // pulse start_in during HEADER
    int         exp_len;
    logic [7:0] exp_riff0;  // RIFF size low byte
    logic [7:0] exp_last;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] samples [0:7];
  logic [7:0] hdr_tmpl [0:43];
  logic [7:0] got [$];
  logic [7:0] expq [$];
  vec_t       vecs [0:5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_expected(input int n);
    logic [31:0] riff;
    int p;
    p = ((n % 2) == 1) ? P_ODD : 0;
    riff = 32'(36 + n + p);
    expq.delete();
    for (int i = 0; i < 44; i++) expq.push_back(hdr_tmpl[i]);
    for (int i = 0; i < 4; i++) begin
      expq[4 + i]  = riff[8*i +: 8];
      expq[40 + i] = 8'(n >> (8*i));
    end
    for (int i = 0; i < n; i++) expq.push_back(samples[i] ^ 8'h80);
    if (p == 1) expq.push_back(8'h00);
  endtask

  task automatic run_file(input int n, input int pct, input int starve_at, input bit glitch);
    int ptr = 0, starve_cnt = 0, cycles = 0, done_cnt = 0, rdy_seen = 0, taken = 0;
    bit consumed = 0, prev_stall = 0, done_seen = 0, starving = 0;
    logic [7:0] prev_byte = 8'h00;
    got.delete();
    @(posedge clk); #1;
    num_samples_in  = 32'(n);
    start_in        = 1'b1;
    byte_ready_in   = 1'b1;
    sample_valid_in = (n > 0);
    sample_in       = samples[0];
    @(negedge clk);
    chk("idle_before_start", 32'(byte_valid_out), 32'd0);
    @(posedge clk); #1;
    start_in       = 1'b0;
    num_samples_in = 32'd9;
    @(negedge clk);
    chk("first_valid", 32'(byte_valid_out), 32'd1);
    chk("first_byte", 32'(byte_out), 32'h52);
    while (!done_seen && cycles < 3000) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(byte_valid_out), 32'd1);
        chk("stall_byte", 32'(byte_out), 32'(prev_byte));
      end
      prev_stall = byte_valid_out && !byte_ready_in;
      prev_byte  = byte_out;
      if (byte_valid_out && byte_ready_in) got.push_back(byte_out);
      if (sample_valid_in && sample_ready_out) begin
        consumed = 1;
        taken++;
      end
      if (sample_ready_out) rdy_seen++;
      if (starving && starve_cnt >= 2 && pct == 100) chk("starve_drop", 32'(byte_valid_out), 32'd0);
      if (done_out) begin
        done_cnt++;
        done_seen = 1;
        chk("busy_at_done", 32'(busy_out), 32'd0);
      end
      if (!done_seen) begin
        @(posedge clk); #1;
        if (consumed) ptr++;
        consumed = 0;
        starving = (ptr == starve_at) && (starve_cnt < 10);
        if (starving) begin
          starve_cnt++;
          sample_valid_in = 1'b0;
        end else begin
          sample_valid_in = (ptr < n);
        end
        sample_in     = samples[ptr % 8];
        byte_ready_in = ($urandom_range(0, 99) < pct);
        start_in      = glitch && (got.size() == 5);
        @(negedge clk);
        cycles++;
      end
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done_out after %0d cycles, required done_out", cycles);
    end
    sample_valid_in = 1'b0;
    byte_ready_in   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done_out) done_cnt++;
      if (k == 0) chk("idle_after_done", 32'(state_out), 32'd0);
    end
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("samples_taken", 32'(taken), 32'(n));
    if (n == 0) chk("no_sample_ready", 32'(rdy_seen), 32'd0);
  endtask

  task automatic check_stream(input vec_t v);
    int bad = -1;
    build_expected(v.n);
    chk("byte_count", 32'(got.size()), 32'(v.exp_len));
    if (got.size() >= 44) begin
      chk("riff_size0", 32'(got[4]), 32'(v.exp_riff0));
      chk("last_byte", 32'(got[got.size()-1]), 32'(v.exp_last));
    end
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (bad < 0 && got[i] !== expq[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL stream byte %0d: got %0h expected %0h", bad, got[bad], expq[bad]);
    end
  endtask

  initial begin
    logic [7:0] plan_lo [0:7];
    logic [7:0] plan_mid [0:7];
    int ptr;
    samples  = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h12, 8'hC3, 8'h55, 8'hAA};
    hdr_tmpl = '{8'h52, 8'h49, 8'h46, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h57, 8'h41, 8'h56, 8'h45, 8'h66, 8'h6D, 8'h74, 8'h20,
                 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00,
                 8'hE0, 8'h2E, 8'h00, 8'h00, 8'hE0, 8'h2E, 8'h00, 8'h00,
                 8'h01, 8'h00, 8'h08, 8'h00, 8'h64, 8'h61, 8'h74, 8'h61,
                 8'h00, 8'h00, 8'h00, 8'h00};
    plan_lo  = '{8'h52, 8'h49, 8'h46, 8'h46, 8'h28, 8'h00, 8'h00, 8'h00};
    plan_mid = '{8'hE0, 8'h2E, 8'h00, 8'h00, 8'hE0, 8'h2E, 8'h00, 8'h00};
    vecs[0] = '{4, 100, -1, 1'b0, 48, 8'h28, 8'h7F};
    vecs[1] = '{4, 70, -1, 1'b0, 48, 8'h28, 8'h7F};
    vecs[2] = '{0, 100, -1, 1'b0, 44, 8'h24, 8'h00};
    vecs[3] = '{6, 100, 2, 1'b1, 50, 8'h2A, 8'h43};
    vecs[4] = '{3, 100, -1, 1'b0, 47 + P_ODD, 8'(8'h27 + P_ODD), 8'h00};
    vecs[5] = '{5, 60, -1, 1'b1, 49 + P_ODD, 8'(8'h29 + P_ODD), (P_ODD == 1) ? 8'h00 : 8'h92};

    rst_in = 1'b1; start_in = 1'b0; num_samples_in = 32'd0;
    sample_in = 8'h00; sample_valid_in = 1'b0; byte_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(byte_valid_out), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_sready", 32'(sample_ready_out), 32'd0);
    @(posedge clk); #1;
    rst_in = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_file(vecs[v].n, vecs[v].pct, vecs[v].starve_at, vecs[v].glitch);
      check_stream(vecs[v]);
      if (v == 0 && got.size() == 48) begin
        for (int i = 0; i < 8; i++) begin
          chk("plan_bytes_0_7", 32'(got[i]), 32'(plan_lo[i]));
          chk("plan_bytes_24_31", 32'(got[24+i]), 32'(plan_mid[i]));
        end
        chk("plan_dsize", {got[43], got[42], got[41], got[40]}, 32'd4);
        chk("plan_data", {got[44], got[45], got[46], got[47]}, 32'h80FF007F);
      end
    end

    // Reset while data byte 2 is on the port.
    got.delete();
    ptr = 0;
    @(posedge clk); #1;
    num_samples_in = 32'd4; start_in = 1'b1; byte_ready_in = 1'b1;
    sample_valid_in = 1'b1; sample_in = samples[0];
    @(posedge clk); #1;
    start_in = 1'b0;
    for (int c = 0; c < 200 && got.size() < 46; c++) begin
      @(negedge clk);
      if (byte_valid_out && byte_ready_in) got.push_back(byte_out);
      if (sample_valid_in && sample_ready_out) ptr++;
      @(posedge clk); #1;
      sample_in = samples[ptr];
      sample_valid_in = (ptr < 4);
    end
    chk("rst_seq_reached", 32'(got.size()), 32'd46);
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    sample_valid_in = 1'b0;
    chk("midrst_valid", 32'(byte_valid_out), 32'd0);
    chk("midrst_byte", 32'(byte_out), 32'd0);
    chk("midrst_busy", 32'(busy_out), 32'd0);
    chk("midrst_state", 32'(state_out), 32'd0);
    chk("midrst_sready", 32'(sample_ready_out), 32'd0);
    begin
      int dc = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (done_out) dc++;
      end
      chk("midrst_no_done", 32'(dc), 32'd0);
    end
    run_file(vecs[0].n, 100, -1, 1'b0);
    check_stream(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wav_stream_tx.md
Name: wav_stream_tx

Overview:
- Encoder counterpart of the WAV parser: turns a stream of recorded 8-bit mono samples into a canonical 44-byte-header PCM WAV byte stream.
- Byte output uses a valid/ready handshake and feeds the UART transmit path, so captured audio can be sent back to the host.
- Sits in the sys_clk domain, between the playback/readback sample source and the UART transmitter.

Parameters:
- SAMPLE_RATE, 12_000, sample rate written to the fmt chunk; byte rate equals SAMPLE_RATE (mono, 8-bit).
- MAX_SAMPLES_W, 32, width of the sample-count input.

Ports:
- clk_in  input  1  system clock (sys_clk).
- rst_in  input  1  reset; one clock, synchronous, active-high.
- start_in  input  1  pulse; begin a file (ignored unless IDLE).
- num_samples_in  input  MAX_SAMPLES_W  data length in samples; latched on accepted start.
- sample_in  input  8  signed two's-complement sample.
- sample_valid_in  input  1  sample_in valid.
- sample_ready_out  output  1  sample consumed when valid && ready.
- byte_out  output  8  WAV byte.
- byte_valid_out  output  1  byte_out valid.
- byte_ready_in  input  1  downstream accepts byte.
- busy_out  output  1  high from accepted start through the last byte accepted.
- done_out  output  1  one-cycle pulse after the final byte is accepted.
- state_out  output  3  FSM state, for LED debug.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, byte index=0, latched count=0.
- States: IDLE -> HEADER -> DATA -> (PAD) -> DONE -> IDLE. Encoding: IDLE=0, HEADER=1, DATA=2, PAD=3, DONE=4.
- Start timing: start accepted in cycle N; byte_valid_out=1 with byte_out=0x52 ('R') in cycle N+1.
- HEADER emits 44 bytes, all multi-byte fields little-endian:
  - "RIFF"; RIFF size = 36 + D + P.
  - "WAVE".
  - "fmt "; fmt size 16 (4 bytes); audio format 1 (2 bytes); channels 1 (2 bytes).
  - Sample rate SAMPLE_RATE (4 bytes); byte rate SAMPLE_RATE (4 bytes).
  - Block align 1 (2 bytes); bits per sample 8 (2 bytes).
  - "data"; data size D (4 bytes).
  - D = latched count. P = pad byte count (0 unless optional feature).
  - Sums use 32-bit modulo arithmetic.
- Index advances only on byte_valid_out && byte_ready_in. After index 43 is accepted:
  - go to DATA if D>0;
  - otherwise go to PAD/DONE per the feature below.
- DATA:
  - Output byte = {~sample_in[7], sample_in[6:0]} (signed to offset-binary).
  - sample_ready_out = in DATA && remaining>0 && (!byte_valid_out || byte_ready_in).
  - A transfer loads the output register, so throughput is 1 byte/cycle with no bubble.
  - Starvation drops byte_valid_out once the held byte is taken; no byte is ever duplicated.
  - After the D-th sample is accepted, sample_ready_out=0 and the last byte drains before the next state.
- Handshake: byte_out is stable while byte_valid_out && !byte_ready_in. byte_valid_out is never withdrawn before acceptance.
- DONE: one cycle. done_out=1, busy_out=0, then IDLE. A start in DONE is ignored.
- start_in while busy is ignored. A count change mid-file has no effect.
- rst_in mid-file: return to IDLE next cycle and drop byte_valid_out. The partial file is abandoned with no done_out.
- D=0: header only, data size field 0, sample_ready_out never asserts.

Optional Feature:
- Macro: WAV_STREAM_PAD_EN.
- Defined: if D is odd, one 0x00 pad byte is sent in PAD after the data. P=1, so RIFF size = 36+D+1. The data size field stays D.
- Undefined: the PAD state is unreachable, P=0, and odd-length files are emitted unpadded.

Decomposition:
- Shared package wav_pkg, also used by the parser:
  - chunk IDs RIFF_ID, WAVE_ID, FMT_ID, DATA_ID (32-bit ASCII);
  - WAV_HDR_LEN=44, FMT_CHUNK_LEN=16, WAV_FMT_PCM=1;
  - wav_tx_state_t enum.
- Sub-module wav_header_byte: purely combinational; maps (index[5:0], riff_size, data_size, sample_rate) to a header byte.

Test Plan:
- num_samples=4, samples 0x00,0x7F,0x80,0xFF, ready=1 → exactly 48 bytes:
  - bytes 0-7: 52 49 46 46 28 00 00 00;
  - bytes 24-31: E0 2E 00 00 E0 2E 00 00;
  - bytes 40-43: 04 00 00 00;
  - data: 80 FF 00 7F;
  - done_out pulses once, the cycle after byte 47 is accepted.
- Same file with byte_ready_in randomly 30% low → byte_out held stable during every stall and the byte sequence is identical.
- num_samples=0 → 44 bytes, RIFF size 24 00 00 00, data size 00 00 00 00, sample_ready_out never 1.
- sample_valid_in low for 10 cycles mid-DATA → byte_valid_out drops after the held byte is taken, resumes on the next sample, no duplicate or lost bytes.
- start_in pulsed during HEADER → ignored. rst_in asserted at data byte 2 → all outputs 0 next cycle, no done_out. A fresh start then emits 0x52 first.
- num_samples=3:
  - with WAV_STREAM_PAD_EN → 48 bytes, RIFF size 0x28, final byte 0x00;
  - without it → 47 bytes, RIFF size 0x27.
